// File: rtl/border_generator.sv
// border_generator: wall/interior classification for the Snake playfield.
// Provides a combinational classifier for an arbitrary tile, a registered
// copy of it, edge/corner decode, and a raster scanner that walks every
// in-grid tile once per scan so the renderer can paint the walls.
module border_generator #(
   parameter int unsigned GRID_W  = 16,
   parameter int unsigned GRID_H  = 12,
   parameter int unsigned COORD_W = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic               isBorder,
   output logic               isBorder_q,
   output logic [3:0]         edge_code,
   output logic               isCorner,
   output logic               outOfRange,
   input  logic               scan_start,
   output logic               scan_valid,
   output logic [COORD_W-1:0] scan_x,
   output logic [COORD_W-1:0] scan_y,
   output logic               scan_border,
   output logic               scan_done
);

   localparam logic [COORD_W-1:0] LP_X_LAST = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] LP_Y_LAST = COORD_W'(GRID_H - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   // ---------------------------------------------------------------------
   // Combinational classifier for the (x, y) input
   // ---------------------------------------------------------------------
   logic w_top;
   logic w_bottom;
   logic w_left;
   logic w_right;
   logic w_x_oor;
   logic w_y_oor;

   assign w_top    = (y == '0);
   assign w_bottom = (y == LP_Y_LAST);
   assign w_left   = (x == '0);
   assign w_right  = (x == LP_X_LAST);

   // When the grid dimension fills the whole coordinate range no value can
   // be out of range, so the comparison is dropped rather than truncated.
   if (GRID_W < (32'd1 << COORD_W)) begin : g_x_oor
      assign w_x_oor = (x >= COORD_W'(GRID_W));
   end else begin : g_x_full
      assign w_x_oor = 1'b0;
   end

   if (GRID_H < (32'd1 << COORD_W)) begin : g_y_oor
      assign w_y_oor = (y >= COORD_W'(GRID_H));
   end else begin : g_y_full
      assign w_y_oor = 1'b0;
   end

   assign outOfRange = w_x_oor | w_y_oor;
   assign isBorder   = w_top | w_bottom | w_left | w_right | outOfRange;

   // Edge bits come from the raw comparisons only; out-of-range tiles are
   // walls but sit on no particular edge.
   assign edge_code  = {w_top, w_bottom, w_left, w_right};

   // Two or more edge bits set. Same-axis pairs only matter for degenerate
   // one-tile-wide grids.
   assign isCorner   = ((w_top | w_bottom) & (w_left | w_right))
                     | (w_top & w_bottom)
                     | (w_left & w_right);

   // ---------------------------------------------------------------------
   // Registered copy of the classifier
   // ---------------------------------------------------------------------
   logic r_isBorder_q;

   // Delay isBorder by one clock; cleared by reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_isBorder_q <= 1'b0;
      end else begin
         r_isBorder_q <= isBorder;
      end
   end

   assign isBorder_q = r_isBorder_q;

   // ---------------------------------------------------------------------
   // Raster border scanner
   // ---------------------------------------------------------------------
   scan_state_t        r_state;
   logic               r_scan_valid;
   logic [COORD_W-1:0] r_scan_x;
   logic [COORD_W-1:0] r_scan_y;
   logic               r_scan_done;

   logic               w_scan_last_col;
   logic [COORD_W-1:0] w_next_x;
   logic [COORD_W-1:0] w_next_y;
   logic               w_next_is_last;

   assign w_scan_last_col = (r_scan_x == LP_X_LAST);
   assign w_next_x        = w_scan_last_col ? '0 : (r_scan_x + 1'b1);
   assign w_next_y        = w_scan_last_col ? (r_scan_y + 1'b1) : r_scan_y;
   assign w_next_is_last  = (w_next_x == LP_X_LAST) && (w_next_y == LP_Y_LAST);

   // Scanner FSM: idle until a start pulse, then one tile per clock in raster
   // order; scan_done is precomputed so it lines up with the final tile.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state      <= ST_IDLE;
         r_scan_valid <= 1'b0;
         r_scan_x     <= '0;
         r_scan_y     <= '0;
         r_scan_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (scan_start) begin
                  r_state      <= ST_SCAN;
                  r_scan_valid <= 1'b1;
                  r_scan_x     <= '0;
                  r_scan_y     <= '0;
                  r_scan_done  <= (LP_X_LAST == '0) && (LP_Y_LAST == '0);
               end
            end
            ST_SCAN: begin
               // scan_start is deliberately not examined here, so pulses
               // during a scan or on its final edge are dropped.
               if (r_scan_done) begin
                  r_state      <= ST_IDLE;
                  r_scan_valid <= 1'b0;
                  r_scan_x     <= '0;
                  r_scan_y     <= '0;
                  r_scan_done  <= 1'b0;
               end else begin
                  r_scan_x     <= w_next_x;
                  r_scan_y     <= w_next_y;
                  r_scan_done  <= w_next_is_last;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_scan_valid <= 1'b0;
               r_scan_x     <= '0;
               r_scan_y     <= '0;
               r_scan_done  <= 1'b0;
            end
         endcase
      end
   end

   // Scanner coordinates never leave the grid, so only the edge tests are
   // needed to classify them.
   logic w_scan_edge;
   assign w_scan_edge = (r_scan_x == '0) | (r_scan_x == LP_X_LAST)
                      | (r_scan_y == '0) | (r_scan_y == LP_Y_LAST);

   assign scan_valid  = r_scan_valid;
   assign scan_x      = r_scan_x;
   assign scan_y      = r_scan_y;
   assign scan_done   = r_scan_done;
   assign scan_border = r_scan_valid & w_scan_edge;

endmodule

// File: tb/tb_border_generator.sv
// Testbench for border_generator: reference model derived from the playfield
// rules (16x12 grid, walls on the outer ring, out-of-grid tiles are walls).
module tb_border_generator;

   localparam int W = 16;
   localparam int H = 12;
   localparam int CELLS = W * H;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [3:0] x = '0;
   logic [3:0] y = '0;
   logic       isBorder;
   logic       isBorder_q;
   logic [3:0] edge_code;
   logic       isCorner;
   logic       outOfRange;
   logic       scan_start = 1'b0;
   logic       scan_valid;
   logic [3:0] scan_x;
   logic [3:0] scan_y;
   logic       scan_border;
   logic       scan_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   border_generator #(
      .GRID_W (16),
      .GRID_H (12),
      .COORD_W(4)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .x          (x),
      .y          (y),
      .isBorder   (isBorder),
      .isBorder_q (isBorder_q),
      .edge_code  (edge_code),
      .isCorner   (isCorner),
      .outOfRange (outOfRange),
      .scan_start (scan_start),
      .scan_valid (scan_valid),
      .scan_x     (scan_x),
      .scan_y     (scan_y),
      .scan_border(scan_border),
      .scan_done  (scan_done)
   );

   // ---------------- reference model ----------------
   function automatic bit m_oor(input int cx, input int cy);
      return (cx >= W) || (cy >= H);
   endfunction

   function automatic bit m_border(input int cx, input int cy);
      return (cx == 0) || (cx == W - 1) || (cy == 0) || (cy == H - 1) || m_oor(cx, cy);
   endfunction

   function automatic logic [3:0] m_edges(input int cx, input int cy);
      return {cy == 0, cy == H - 1, cx == 0, cx == W - 1};
   endfunction

   function automatic bit m_corner(input int cx, input int cy);
      logic [3:0] e;
      e = m_edges(cx, cy);
      return (int'(e[3]) + int'(e[2]) + int'(e[1]) + int'(e[0])) >= 2;
   endfunction

   // Expected scanner output for cell index i: {valid, x, y, border, done}
   function automatic logic [10:0] m_scan_cell(input int i);
      int cx;
      int cy;
      cx = i % W;
      cy = i / W;
      return {1'b1, 4'(cx), 4'(cy), m_border(cx, cy), i == CELLS - 1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nrst = 1'b0;
      x = 4'd0;
      y = 4'd0;
      tick();
      tick();
      total++;
      if ({isBorder_q, scan_valid, scan_x, scan_y, scan_done, scan_border} !== 12'b0) begin
         bad++;
         $display("FAIL reset_state: got q=%b v=%b sx=%0d sy=%0d done=%b sb=%b want all 0",
                  isBorder_q, scan_valid, scan_x, scan_y, scan_done, scan_border);
      end
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_comb_sweep();
      for (int cy = 0; cy < 16; cy++) begin
         for (int cx = 0; cx < 16; cx++) begin
            x = 4'(cx);
            y = 4'(cy);
            #1;
            total++;
            if ({isBorder, outOfRange, edge_code, isCorner} !==
                {m_border(cx, cy), m_oor(cx, cy), m_edges(cx, cy), m_corner(cx, cy)}) begin
               bad++;
               $display("FAIL comb_sweep (%0d,%0d): got b=%b oor=%b e=%b c=%b want b=%b oor=%b e=%b c=%b",
                        cx, cy, isBorder, outOfRange, edge_code, isCorner,
                        m_border(cx, cy), m_oor(cx, cy), m_edges(cx, cy), m_corner(cx, cy));
            end
         end
      end
   endtask

   task automatic test_spot_checks();
      int sx[10]      = '{0, 15, 7, 7, 7, 1, 14, 5, 0, 15};
      int sy[10]      = '{5, 3, 0, 11, 5, 1, 10, 13, 0, 11};
      bit sb[10]      = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
      logic [3:0] se[10] = '{4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0000,
                             4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0101};
      bit sc[10]      = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      bit so[10]      = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      for (int i = 0; i < 10; i++) begin
         x = 4'(sx[i]);
         y = 4'(sy[i]);
         #1;
         total++;
         if ({isBorder, edge_code, isCorner, outOfRange} !== {sb[i], se[i], sc[i], so[i]}) begin
            bad++;
            $display("FAIL spot (%0d,%0d): got b=%b e=%b c=%b oor=%b want b=%b e=%b c=%b oor=%b",
                     sx[i], sy[i], isBorder, edge_code, isCorner, outOfRange,
                     sb[i], se[i], sc[i], so[i]);
         end
      end
   endtask

   task automatic test_comb_random();
      for (int i = 0; i < 64; i++) begin
         int cx;
         int cy;
         cx = int'($urandom_range(15, 0));
         cy = int'($urandom_range(15, 0));
         x = 4'(cx);
         y = 4'(cy);
         #1;
         total++;
         if ({isBorder, outOfRange, edge_code, isCorner} !==
             {m_border(cx, cy), m_oor(cx, cy), m_edges(cx, cy), m_corner(cx, cy)}) begin
            bad++;
            $display("FAIL comb_random (%0d,%0d): got b=%b oor=%b e=%b c=%b", cx, cy,
                     isBorder, outOfRange, edge_code, isCorner);
         end
      end
   endtask

   task automatic test_registered();
      int vx[2] = '{3, 3};
      int vy[2] = '{0, 4};
      bit expq;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         x = 4'(vx[i]);
         y = 4'(vy[i]);
         expq = m_border(vx[i], vy[i]);
         tick();
         total++;
         if (isBorder_q !== expq) begin
            bad++;
            $display("FAIL reg_fixed (%0d,%0d): got q=%b want %b", vx[i], vy[i], isBorder_q, expq);
         end
      end
      for (int i = 0; i < 32; i++) begin
         int cx;
         int cy;
         cx = int'($urandom_range(15, 0));
         cy = int'($urandom_range(15, 0));
         @(negedge clk);
         x = 4'(cx);
         y = 4'(cy);
         expq = m_border(cx, cy);
         tick();
         total++;
         if (isBorder_q !== expq) begin
            bad++;
            $display("FAIL reg_random (%0d,%0d): got q=%b want %b", cx, cy, isBorder_q, expq);
         end
      end
      // Reset with a wall tile on the input: register must still clear.
      @(negedge clk);
      x = 4'd0;
      y = 4'd0;
      nrst = 1'b0;
      tick();
      total++;
      if (isBorder_q !== 1'b0) begin
         bad++;
         $display("FAIL reg_reset: got q=%b want 0", isBorder_q);
      end
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_scan_raster();
      int nvalid = 0;
      @(negedge clk);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      for (int i = 0; i < CELLS; i++) begin
         total++;
         if (scan_valid) nvalid++;
         if ({scan_valid, scan_x, scan_y, scan_border, scan_done} !== m_scan_cell(i)) begin
            bad++;
            $display("FAIL scan_cell %0d: got v=%b x=%0d y=%0d b=%b d=%b want %b",
                     i, scan_valid, scan_x, scan_y, scan_border, scan_done, m_scan_cell(i));
         end
         tick();
      end
      total++;
      if (nvalid != CELLS) begin
         bad++;
         $display("FAIL scan_count: got %0d valid cycles want %0d", nvalid, CELLS);
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({scan_valid, scan_x, scan_y, scan_border, scan_done} !== 11'b0) begin
            bad++;
            $display("FAIL scan_idle_after %0d: got v=%b x=%0d y=%0d b=%b d=%b want all 0",
                     k, scan_valid, scan_x, scan_y, scan_border, scan_done);
         end
         tick();
      end
   endtask

   task automatic test_scan_restart_ignored();
      @(negedge clk);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      for (int i = 0; i < CELLS; i++) begin
         total++;
         if ({scan_valid, scan_x, scan_y, scan_border, scan_done} !== m_scan_cell(i)) begin
            bad++;
            $display("FAIL restart_cell %0d: got v=%b x=%0d y=%0d b=%b d=%b want %b",
                     i, scan_valid, scan_x, scan_y, scan_border, scan_done, m_scan_cell(i));
         end
         // Pulse at (4,2) mid-scan and again on the finishing edge.
         if (i == 2 * W + 4 || i == CELLS - 1) scan_start = 1'b1;
         tick();
         scan_start = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({scan_valid, scan_x, scan_y, scan_done} !== 10'b0) begin
            bad++;
            $display("FAIL restart_finish_idle %0d: got v=%b x=%0d y=%0d d=%b want all 0",
                     k, scan_valid, scan_x, scan_y, scan_done);
         end
         tick();
      end
   endtask

   task automatic test_scan_reset_mid();
      int stop_at;
      bit seen;
      stop_at = 6 * W + 8;
      seen = 1'b0;
      @(negedge clk);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      for (int i = 0; i < CELLS && !seen; i++) begin
         if (i == stop_at) begin
            total++;
            if ({scan_x, scan_y} !== {4'd8, 4'd6}) begin
               bad++;
               $display("FAIL reset_mid_reach: got x=%0d y=%0d want 8,6", scan_x, scan_y);
            end
            nrst = 1'b0;
            seen = 1'b1;
         end
         tick();
      end
      total++;
      if ({scan_valid, scan_x, scan_y, scan_done, isBorder_q} !== 11'b0) begin
         bad++;
         $display("FAIL reset_mid: got v=%b x=%0d y=%0d d=%b q=%b want all 0",
                  scan_valid, scan_x, scan_y, scan_done, isBorder_q);
      end
      @(negedge clk);
      nrst = 1'b1;
      tick();
      total++;
      if (scan_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_stays_idle: got v=%b want 0", scan_valid);
      end
   endtask

   initial begin
      test_reset();
      test_comb_sweep();
      test_spot_checks();
      test_comb_random();
      test_registered();
      test_scan_raster();
      test_scan_restart_ignored();
      test_scan_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
